// File: rtl/ether_rx_frame_check_if.sv
// ether_rx_frame_check_if: GMII RX pins plus the cleaned frame stream; ETHER_RX_STATS_EN adds good/bad frame counters
interface ether_rx_frame_check_if;
  logic phy_rx_dv;
  logic phy_rx_er;
  logic [7:0] phy_rx_data;
  logic rx_valid;
  logic [7:0] rx_data;
  logic rx_sof;
  logic rx_eof;
  logic rx_good;
  logic rx_bad;
  logic [11:0] frame_len;
`ifdef ETHER_RX_STATS_EN
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
  modport master (
    input phy_rx_dv, phy_rx_er, phy_rx_data,
    output rx_valid, rx_data, rx_sof, rx_eof, rx_good, rx_bad, frame_len, good_cnt, bad_cnt
  );
  modport slave (
    output phy_rx_dv, phy_rx_er, phy_rx_data,
    input rx_valid, rx_data, rx_sof, rx_eof, rx_good, rx_bad, frame_len, good_cnt, bad_cnt
  );
`else
  modport master (
    input phy_rx_dv, phy_rx_er, phy_rx_data,
    output rx_valid, rx_data, rx_sof, rx_eof, rx_good, rx_bad, frame_len
  );
  modport slave (
    output phy_rx_dv, phy_rx_er, phy_rx_data,
    input rx_valid, rx_data, rx_sof, rx_eof, rx_good, rx_bad, frame_len
  );
`endif
endinterface

// File: rtl/ether_rx_frame_check.sv
// ether_rx_frame_check: GMII RX preamble strip, CRC-32 check and FCS-hiding 4-byte delay; ETHER_RX_STATS_EN adds good_cnt/bad_cnt
module ether_rx_frame_check #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input logic phy_rx_clk,
  input logic rst,
  ether_rx_frame_check_if.master bus
);
  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [3:0] PRE_N = 4'(PREAMBLE_LEN);
  localparam logic [11:0] MIN_N = 12'(MIN_FRAME_LEN);
  localparam logic [11:0] MAX_N = 12'(MAX_FRAME_LEN);
  typedef enum logic [2:0] {IDLE, PRE, DATA, EOF, DROP} state_t;
  state_t state, state_d;
  logic dv, is_pre, is_sfd, take;
  logic [3:0] pre_cnt;
  logic [11:0] byte_cnt;
  logic [31:0] crc;
  logic [3:0][7:0] dly;
  logic er_seen;
  logic valid_d, sof_d, eof_d, good_d, bad_d;
  logic [7:0] data_d;
  logic [11:0] len_d;
  assign dv = bus.phy_rx_dv;
  assign is_pre = bus.phy_rx_data == 8'h55;
  assign is_sfd = bus.phy_rx_data == 8'hD5;
  assign take = state == DATA && dv;
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ POLY : r >> 1;
    return r;
  endfunction
  // state register
  always_ff @(posedge phy_rx_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  // next state; EOF listens like IDLE so a preamble right after the end cycle is not lost
  always_comb begin
    state_d = state;
    case (state)
      IDLE, EOF: state_d = !dv ? IDLE : is_pre ? PRE : DROP;
      PRE: state_d = !dv ? IDLE : is_pre ? PRE : (is_sfd && pre_cnt == PRE_N) ? DATA : DROP;
      DATA: state_d = dv ? DATA : EOF;
      DROP: state_d = dv ? DROP : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // next output values; the oldest delay-line byte leaves once four newer bytes sit behind it
  always_comb begin
    valid_d = take && byte_cnt >= 12'd4;
    sof_d = take && byte_cnt == 12'd4;
    data_d = valid_d ? dly[3] : 8'h00;
    eof_d = state == DATA && !dv;
    good_d = eof_d && crc == RESIDUE && byte_cnt >= MIN_N && byte_cnt <= MAX_N && !er_seen;
    bad_d = eof_d && !good_d;
    len_d = eof_d ? byte_cnt : 12'd0;
  end
  // crc, counters and delay line; everything re-inits outside DATA so each frame starts clean
  always_ff @(posedge phy_rx_clk or posedge rst) begin
    if (rst) begin
      crc <= 32'hFFFFFFFF;
      byte_cnt <= 12'd0;
      dly <= '0;
      er_seen <= 1'b0;
      pre_cnt <= 4'd0;
    end else begin
      if (take) begin
        crc <= crc_step(crc, bus.phy_rx_data);
        dly <= {dly[2:0], bus.phy_rx_data};
        byte_cnt <= byte_cnt + {11'd0, byte_cnt != 12'hFFF};
        er_seen <= er_seen | bus.phy_rx_er;
      end else if (state != DATA) begin
        crc <= 32'hFFFFFFFF;
        byte_cnt <= 12'd0;
        dly <= '0;
        er_seen <= 1'b0;
      end
      pre_cnt <= (state == IDLE || state == EOF) ? ((dv && is_pre) ? 4'd1 : 4'd0) :
                 state != PRE ? 4'd0 :
                 (dv && is_pre && pre_cnt != 4'hF) ? pre_cnt + 4'd1 : pre_cnt;
    end
  end
  // registered outputs
  always_ff @(posedge phy_rx_clk or posedge rst) begin
    if (rst) begin
      bus.rx_valid <= 1'b0;
      bus.rx_data <= 8'h00;
      bus.rx_sof <= 1'b0;
      bus.rx_eof <= 1'b0;
      bus.rx_good <= 1'b0;
      bus.rx_bad <= 1'b0;
      bus.frame_len <= 12'd0;
    end else begin
      bus.rx_valid <= valid_d;
      bus.rx_data <= data_d;
      bus.rx_sof <= sof_d;
      bus.rx_eof <= eof_d;
      bus.rx_good <= good_d;
      bus.rx_bad <= bad_d;
      bus.frame_len <= len_d;
    end
  end
`ifdef ETHER_RX_STATS_EN
  // saturating verdict counters, updated together with the eof pulse
  always_ff @(posedge phy_rx_clk or posedge rst) begin
    if (rst) begin
      bus.good_cnt <= 16'd0;
      bus.bad_cnt <= 16'd0;
    end else begin
      if (good_d && bus.good_cnt != 16'hFFFF) bus.good_cnt <= bus.good_cnt + 16'd1;
      if (bad_d && bus.bad_cnt != 16'hFFFF) bus.bad_cnt <= bus.bad_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: doc/ether_rx_frame_check.md
Name: ether_rx_frame_check

Overview:
- GMII receive front end between the PHY RX pins and the UDP demo RX stage.
- Strips preamble/SFD, computes Ethernet CRC-32, and delays payload 4 bytes so the FCS never appears on the output.
- Emits a clean byte stream with start/end markers plus a per-frame good/bad verdict and length, so the downstream parser stops doing its own preamble hunting and can discard corrupt frames.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes required before 0xD5 SFD
MIN_FRAME_LEN, 64, minimum post-SFD byte count including FCS for a good frame
MAX_FRAME_LEN, 1518, maximum post-SFD byte count including FCS for a good frame

Ports:
phy_rx_clk  input  1  receive clock, 125 MHz GMII; all logic on rising edge
rst  input  1  asynchronous, active-high reset
phy_rx_dv  input  1  GMII data valid
phy_rx_er  input  1  GMII receive error
phy_rx_data  input  8  GMII receive byte
rx_valid  output  1  rx_data holds a frame byte (DA first, FCS excluded)
rx_data  output  8  frame byte
rx_sof  output  1  high with rx_valid on the first frame byte
rx_eof  output  1  one-cycle end-of-frame pulse; rx_valid low on that cycle
rx_good  output  1  valid only with rx_eof: CRC ok, length in range, no rx_er
rx_bad  output  1  valid only with rx_eof: complement of rx_good
frame_len  output  12  valid with rx_eof: post-SFD bytes incl. FCS, saturates at 4095

Behaviour:
- Reset: all outputs 0, state IDLE, CRC = 0xFFFFFFFF, counters 0, delay line cleared. All outputs registered.
- States:
  - IDLE: dv=1 and byte 0x55 -> PRE, pre_cnt=1. Any other byte while dv=1 -> DROP.
  - PRE: 0x55 increments pre_cnt, saturating at 15. 0xD5 with pre_cnt==PREAMBLE_LEN -> DATA. Any other byte, or 0xD5 with the wrong count -> DROP. dv=0 -> IDLE, no eof.
  - DATA: each dv=1 byte updates the CRC and shifts into the 4-byte delay line; byte_cnt increments, saturating at 4095. dv=0 -> EOF.
  - EOF: one cycle. Pulse rx_eof and present the status outputs, then re-init the CRC, clear counters and the delay line, -> IDLE.
  - DROP: wait for dv=0, then -> IDLE. No output and no eof.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, LSB-first, 8 bits per cycle.
  - Computed over every post-SFD byte including the FCS.
  - Match when the register equals the residue 0xDEBB20E3 after the last byte.
- Output timing:
  - Byte k (k from 0) is driven on rx_data with rx_valid=1 the cycle after byte k+4 is sampled, i.e. 5-cycle latency from the pin.
  - The 4 FCS bytes remain in the delay line and are discarded at EOF.
  - rx_sof is high on the first rx_valid of a frame.
- rx_good = crc_match & MIN_FRAME_LEN<=byte_cnt<=MAX_FRAME_LEN & no rx_er seen while dv=1 in DATA.
- Runts:
  - A frame of 0–4 post-SFD bytes emits no rx_valid.
  - It still emits rx_eof with rx_bad=1 and frame_len=count.
- Back-to-back frames: the EOF cycle consumes the first cycle of the IFG. A new preamble starting on the cycle after EOF is accepted.
- Reset mid-frame: outputs drop to 0 immediately; no eof is produced for the aborted frame.

Optional Feature:
- ETHER_RX_STATS_EN defined:
  - Adds outputs good_cnt[15:0] and bad_cnt[15:0].
  - Each counts rx_eof pulses with rx_good / rx_bad respectively.
  - Counters saturate at 0xFFFF and are reset to 0 by rst.
  - DROP-state frames count as neither.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Minimal good frame: 7x55, D5, 60 payload bytes 0x00..0x3B, correct FCS -> 60 rx_valid bytes 0x00..0x3B, rx_sof on 0x00, rx_eof with rx_good=1, frame_len=64; first rx_valid 5 cycles after the first DA byte is on the pins.
- Same frame with byte 10 flipped -> 60 bytes still emitted, rx_eof with rx_bad=1, frame_len=64.
- Short preamble (6x55, D5) or 0x5D instead of D5 -> no rx_valid, no rx_eof; a good frame sent 12 IFG cycles later is accepted normally.
- Runt: 7x55, D5, 3 bytes -> no rx_valid, rx_eof with rx_bad=1, frame_len=3. 1519-byte frame with valid FCS -> rx_bad=1, frame_len=1519.
- phy_rx_er pulsed 1 cycle mid-payload of an otherwise good 64-byte frame -> rx_bad=1. Two good frames with a 1-cycle dv gap -> two rx_eof pulses, both rx_good.
- rst asserted mid-payload -> all outputs 0 on the next edge, no rx_eof. With ETHER_RX_STATS_EN: 3 good + 2 bad frames -> good_cnt=3, bad_cnt=2.
